// File: rtl/life_frame_streamer.sv
// Snapshots a Game of Life grid on request and streams it one row per beat over valid/ready,
// then reports the frame's live-cell population for one cycle.
module life_frame_streamer #(
   parameter int unsigned M     = 16,
   parameter int unsigned N     = 16,
   parameter int unsigned ROW_W = (N > 1) ? $clog2(N) : 1,
   parameter int unsigned POP_W = $clog2(M * N + 1)
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [N*M-1:0]     state_i,
   input  logic               frame_req_i,
   output logic               busy_o,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [M-1:0]       m_data_o,
   output logic [ROW_W-1:0]   m_row_o,
   output logic               m_last_o,
   output logic [POP_W-1:0]   pop_o,
   output logic               pop_valid_o,
   output logic               req_dropped_o
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e                r_state, w_state_nxt;
   logic [N-1:0][M-1:0]   r_snap, w_snap_nxt;
   logic [ROW_W-1:0]      r_row, w_row_nxt;
   logic [POP_W-1:0]      r_acc, w_acc_nxt;
   logic [POP_W-1:0]      r_pop, w_pop_nxt;
   logic                  r_pend, w_pend_nxt;
   logic                  r_drop, w_drop_nxt;
   logic                  r_req_prev;
   logic [M-1:0]          w_row_data;
   logic [POP_W-1:0]      w_row_pop;
   logic                  w_last;
   logic                  w_restart;

   function automatic logic [POP_W-1:0] popcnt(input logic [M-1:0] v);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < M; i++) c = c + POP_W'(v[i]);
      return c;
   endfunction

   assign w_row_data = r_snap[r_row];
   assign w_row_pop  = popcnt(w_row_data);
   assign w_last     = (r_row == ROW_W'(N - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_snap_nxt  = r_snap;
      w_row_nxt   = r_row;
      w_acc_nxt   = r_acc;
      w_pop_nxt   = r_pop;
      w_pend_nxt  = r_pend;
      w_drop_nxt  = r_drop;
      w_restart   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (frame_req_i) w_restart = 1'b1;
         end
         StSend: begin
            if (m_ready_i) begin
               w_acc_nxt = r_acc + w_row_pop;
               if (w_last) begin
                  w_pop_nxt   = r_acc + w_row_pop;
                  w_state_nxt = StDone;
               end else begin
                  w_row_nxt = r_row + ROW_W'(1);
               end
            end
            // A held request is one request; only a fresh assertion while queued is lost.
            if (frame_req_i) begin
               if (!r_pend) w_pend_nxt = 1'b1;
               else if (!r_req_prev) w_drop_nxt = 1'b1;
            end
         end
         StDone: begin
            if (r_pend) begin
               w_restart  = 1'b1;
               w_pend_nxt = frame_req_i;
            end else if (frame_req_i) begin
               w_restart = 1'b1;
            end else begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
      if (w_restart) begin
         w_snap_nxt  = state_i;
         w_row_nxt   = '0;
         w_acc_nxt   = '0;
         w_state_nxt = StSend;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= StIdle;
         r_snap     <= '0;
         r_row      <= '0;
         r_acc      <= '0;
         r_pop      <= '0;
         r_pend     <= 1'b0;
         r_drop     <= 1'b0;
         r_req_prev <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_snap     <= w_snap_nxt;
         r_row      <= w_row_nxt;
         r_acc      <= w_acc_nxt;
         r_pop      <= w_pop_nxt;
         r_pend     <= w_pend_nxt;
         r_drop     <= w_drop_nxt;
         r_req_prev <= frame_req_i;
      end
   end

   assign busy_o        = (r_state != StIdle);
   assign m_valid_o     = (r_state == StSend);
   assign m_data_o      = m_valid_o ? w_row_data : '0;
   assign m_row_o       = m_valid_o ? r_row : '0;
   assign m_last_o      = m_valid_o & w_last;
   assign pop_o         = r_pop;
   assign pop_valid_o   = (r_state == StDone);
   assign req_dropped_o = r_drop;

endmodule
